// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: VGA scan-out for the 4x4 cell bank. Stage 0 holds the
// pixel counters and their decode, stage 1 drives the bank address and
// registers the decode, and stage 2 registers sync, data-enable and colour.
module vga_tile_renderer #(
    parameter int          BIT_ADDR  = 4,
    parameter int          BIT_DATO  = 3,
    parameter int          TILE_LOG2 = 6,
    parameter int          GRID_X0   = 192,
    parameter int          GRID_Y0   = 112,
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter logic [11:0] BG_COLOR  = 12'h444
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_en,
    input  logic [BIT_ADDR-1:0] cursor_addr,
    output logic [BIT_ADDR-1:0] addrR,
    input  logic [BIT_DATO-1:0] datOutR,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic [11:0]         rgb,
    output logic                frame_start
);

    localparam int HALF    = BIT_ADDR / 2;
    localparam int LOC_W   = TILE_LOG2 + HALF;
    localparam int GRID_PX = 1 << LOC_W;

    localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] GX_BEG  = 10'(GRID_X0);
    localparam logic [9:0] GX_END  = 10'(GRID_X0 + GRID_PX);
    localparam logic [9:0] GY_BEG  = 10'(GRID_Y0);
    localparam logic [9:0] GY_END  = 10'(GRID_Y0 + GRID_PX);

    localparam logic [TILE_LOG2-1:0] EDGE_LO = TILE_LOG2'(2);
    localparam logic [TILE_LOG2-1:0] EDGE_HI = TILE_LOG2'((1 << TILE_LOG2) - 3);

    // Stage 0 state and decode
    logic [9:0]          hcount, vcount;
    logic [LOC_W-1:0]    x_loc, y_loc;
    logic [HALF-1:0]     col, row;
    logic [TILE_LOG2-1:0] lx, ly;
    logic [BIT_ADDR-1:0] tile_addr;
    logic                in_grid, border, active, hsync_n, vsync_n;
    logic                last_pixel;

    // Stage 1 registers
    logic                s1_in_grid, s1_border, s1_active, s1_hsync_n, s1_vsync_n;

    // Stage 2 colour selection
    logic [11:0]         lut_color, rgb_next;

    // Pixel counters: hcount sweeps a line, vcount advances on each line wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                if (vcount == V_LAST)
                    vcount <= '0;
                else
                    vcount <= vcount + 10'd1;
            end else begin
                hcount <= hcount + 10'd1;
            end
        end
    end

    // Stage 0 decode: grid membership, tile coordinates, cursor frame, sync
    always_comb begin
        x_loc      = LOC_W'(hcount - GX_BEG);
        y_loc      = LOC_W'(vcount - GY_BEG);
        in_grid    = (hcount >= GX_BEG) && (hcount < GX_END) &&
                     (vcount >= GY_BEG) && (vcount < GY_END);
        col        = x_loc[TILE_LOG2 +: HALF];
        row        = y_loc[TILE_LOG2 +: HALF];
        lx         = x_loc[TILE_LOG2-1:0];
        ly         = y_loc[TILE_LOG2-1:0];
        tile_addr  = {row, col};
        border     = in_grid &&
                     ((lx < EDGE_LO) || (lx > EDGE_HI) || (ly < EDGE_LO) || (ly > EDGE_HI)) &&
                     (tile_addr == cursor_addr);
        active     = (hcount < H_ACT) && (vcount < V_ACT);
        hsync_n    = !((hcount >= HS_BEG) && (hcount < HS_END));
        vsync_n    = !((vcount >= VS_BEG) && (vcount < VS_END));
        last_pixel = (hcount == H_LAST) && (vcount == V_LAST);
    end

    // Frame start pulse: one clk after the tick that wraps the counters to (0,0)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            frame_start <= 1'b0;
        else
            frame_start <= pix_en && last_pixel;
    end

    // Stage 1: bank address (held outside the grid) and registered decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addrR      <= '0;
            s1_in_grid <= 1'b0;
            s1_border  <= 1'b0;
            s1_active  <= 1'b0;
            s1_hsync_n <= 1'b1;
            s1_vsync_n <= 1'b1;
        end else if (pix_en) begin
            if (in_grid)
                addrR <= tile_addr;
            s1_in_grid <= in_grid;
            s1_border  <= border;
            s1_active  <= active;
            s1_hsync_n <= hsync_n;
            s1_vsync_n <= vsync_n;
        end
    end

    // Cell value to RGB444, then priority: blanking, cursor frame, cell, background
    always_comb begin
        case (datOutR)
            3'd0:    lut_color = 12'h000;
            3'd1:    lut_color = 12'hF00;
            3'd2:    lut_color = 12'h0F0;
            3'd3:    lut_color = 12'h00F;
            3'd4:    lut_color = 12'hFF0;
            3'd5:    lut_color = 12'h0FF;
            3'd6:    lut_color = 12'hF0F;
            default: lut_color = 12'hFFF;
        endcase
        if (!s1_active)
            rgb_next = 12'h000;
        else if (s1_border)
            rgb_next = 12'hFFF;
        else if (s1_in_grid)
            rgb_next = lut_color;
        else
            rgb_next = BG_COLOR;
    end

    // Stage 2: aligned output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
            rgb   <= '0;
        end else if (pix_en) begin
            hsync <= s1_hsync_n;
            vsync <= s1_vsync_n;
            de    <= s1_active;
            rgb   <= rgb_next;
        end
    end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// tb_vga_tile_renderer: two renderers (full 640x480 timing and a scaled-down
// timing so whole frames fit a short run) share clock, reset, pix_en, cursor
// and one bank model, and are checked against a pixel-index reference model.
module tb_vga_tile_renderer;

    typedef struct {
        int unsigned ha, hfp, hsw, hbp, va, vfp, vsw, vbp, gx0, gy0, tl2;
    } cfg_t;

    logic        clk;
    logic        rst;
    logic        pix_en;
    logic [3:0]  cursor;
    logic [2:0]  mem [16];

    logic [3:0]  b_addr, s_addr;
    logic [2:0]  b_dat, s_dat;
    logic        b_hs, b_vs, b_de, b_fs;
    logic        s_hs, s_vs, s_de, s_fs;
    logic [11:0] b_rgb, s_rgb;
    logic [15:0] b_obs, s_obs, exp_b, exp_s;

    cfg_t        cfg_big, cfg_small;
    int unsigned n;
    logic        last_en;
    logic [3:0]  cur_e1, cur_e2;
    int          checks, errors;

    assign b_dat = mem[b_addr];
    assign s_dat = mem[s_addr];
    assign b_obs = {b_hs, b_vs, b_de, b_rgb, b_fs};
    assign s_obs = {s_hs, s_vs, s_de, s_rgb, s_fs};

    vga_tile_renderer u_big (
        .clk(clk), .rst(rst), .pix_en(pix_en), .cursor_addr(cursor),
        .addrR(b_addr), .datOutR(b_dat), .hsync(b_hs), .vsync(b_vs),
        .de(b_de), .rgb(b_rgb), .frame_start(b_fs)
    );

    vga_tile_renderer #(
        .TILE_LOG2(3), .GRID_X0(16), .GRID_Y0(8),
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(pix_en), .cursor_addr(cursor),
        .addrR(s_addr), .datOutR(s_dat), .hsync(s_hs), .vsync(s_vs),
        .de(s_de), .rgb(s_rgb), .frame_start(s_fs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] lut(input logic [2:0] d);
        case (d)
            3'd0: return 12'h000;
            3'd1: return 12'hF00;
            3'd2: return 12'h0F0;
            3'd3: return 12'h00F;
            3'd4: return 12'hFF0;
            3'd5: return 12'h0FF;
            3'd6: return 12'hF0F;
            default: return 12'hFFF;
        endcase
    endfunction

    // Expected {hsync, vsync, de, rgb, frame_start} after k pix_en ticks since reset release
    function automatic logic [15:0] model(input cfg_t c, input int unsigned k,
                                          input logic [3:0] cur, input logic en);
        int unsigned ht, vt, p, h, v, tile, gw, col, row, lx, ly, t;
        logic hs, vs, act, ing, brd, fs;
        logic [11:0] color;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        fs = en && (k > 0) && (k % (ht * vt) == 0);
        if (k < 2) return {1'b1, 1'b1, 1'b0, 12'h000, fs};
        p    = k - 2;
        h    = p % ht;
        v    = (p / ht) % vt;
        act  = (h < c.ha) && (v < c.va);
        hs   = !((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsw));
        vs   = !((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsw));
        tile = 1 << c.tl2;
        gw   = 4 * tile;
        ing  = (h >= c.gx0) && (h < c.gx0 + gw) && (v >= c.gy0) && (v < c.gy0 + gw);
        t    = 0;
        brd  = 1'b0;
        if (ing) begin
            col = (h - c.gx0) / tile;
            row = (v - c.gy0) / tile;
            lx  = (h - c.gx0) % tile;
            ly  = (v - c.gy0) % tile;
            t   = row * 4 + col;
            brd = ((lx < 2) || (lx + 3 > tile) || (ly < 2) || (ly + 3 > tile)) &&
                  (t[3:0] == cur);
        end
        if (!act)      color = 12'h000;
        else if (brd)  color = 12'hFFF;
        else if (ing)  color = lut(mem[t[3:0]]);
        else           color = 12'h444;
        return {hs, vs, act, color, fs};
    endfunction

    // One clk; inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge
    task automatic cyc(input logic en);
        @(negedge clk);
        pix_en = en;
        @(posedge clk);
        #1;
        last_en = en && rst;
        if (en && rst) begin
            n      = n + 1;
            cur_e2 = cur_e1;
            cur_e1 = cursor;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        pix_en  = 1'b0;
        n       = 0;
        last_en = 1'b0;
        cur_e1  = cursor;
        cur_e2  = cursor;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [20:0] want;
        cursor = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 3'($urandom_range(7));
        do_reset();
        want = {1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 4'h0};
        checks += 2;
        if ({b_obs, b_addr} !== want) begin
            errors++;
            $display("FAIL reset_big got %h want %h", {b_obs, b_addr}, want);
        end
        if ({s_obs, s_addr} !== want) begin
            errors++;
            $display("FAIL reset_small got %h want %h", {s_obs, s_addr}, want);
        end
        cyc(1'b1);
        checks++;
        if (b_obs !== {1'b1, 1'b1, 1'b0, 12'h000, 1'b0}) begin
            errors++;
            $display("FAIL reset_first_tick got %h want %h", b_obs, {1'b1, 1'b1, 1'b0, 12'h000, 1'b0});
        end
    endtask

    task automatic test_line_timing();
        int unsigned fall1, rise1, fall2, de_cnt;
        logic prev_hs;
        fall1 = 0; rise1 = 0; fall2 = 0; de_cnt = 0;
        prev_hs = 1'b1;
        do_reset();
        while (n < 1700) begin
            cyc(1'b1);
            exp_b = model(cfg_big, n, cur_e2, last_en);
            exp_s = model(cfg_small, n, cur_e2, last_en);
            checks += 2;
            if (b_obs !== exp_b) begin
                errors++;
                $display("FAIL line_big n=%0d got %h want %h", n, b_obs, exp_b);
            end
            if (s_obs !== exp_s) begin
                errors++;
                $display("FAIL line_small n=%0d got %h want %h", n, s_obs, exp_s);
            end
            if (prev_hs && !b_hs) begin
                if (fall1 == 0) fall1 = n;
                else if (fall2 == 0) fall2 = n;
            end
            if (!prev_hs && b_hs && rise1 == 0) rise1 = n;
            if (n >= 2 && n <= 801 && b_de) de_cnt++;
            prev_hs = b_hs;
        end
        checks += 4;
        if (fall1 != 658) begin
            errors++;
            $display("FAIL hsync_first_fall got %0d want 658", fall1);
        end
        if (rise1 - fall1 != 96) begin
            errors++;
            $display("FAIL hsync_low_width got %0d want 96", rise1 - fall1);
        end
        if (fall2 - fall1 != 800) begin
            errors++;
            $display("FAIL hsync_period got %0d want 800", fall2 - fall1);
        end
        if (de_cnt != 640) begin
            errors++;
            $display("FAIL de_per_line got %0d want 640", de_cnt);
        end
    endtask

    task automatic test_tile_map();
        logic [2:0] c4;
        for (int i = 0; i < 16; i++) mem[i] = 3'($urandom_range(7));
        mem[6] = 3'd4;
        mem[5] = 3'd2;
        c4 = 3'($urandom_range(7, 1));
        mem[4] = c4;
        cursor = 4'd5;
        do_reset();
        while (n < 1560) begin
            cyc(1'b1);
            if (n == 1538) begin
                checks++;
                if (s_rgb !== lut(c4)) begin
                    errors++;
                    $display("FAIL tile4_edge_rgb got %h want %h", s_rgb, lut(c4));
                end
            end
            if (n == 1546) begin
                checks++;
                if (s_rgb !== 12'hFFF) begin
                    errors++;
                    $display("FAIL cursor_border_rgb got %h want fff", s_rgb);
                end
            end
            if (n == 1549) begin
                checks++;
                if (s_rgb !== 12'h0F0) begin
                    errors++;
                    $display("FAIL cursor_inner_rgb got %h want 0f0", s_rgb);
                end
            end
            if (n == 1556) begin
                checks++;
                if (s_addr !== 4'd6) begin
                    errors++;
                    $display("FAIL tile6_addr got %0d want 6", s_addr);
                end
            end
            if (n == 1557) begin
                checks++;
                if (s_rgb !== 12'hFF0) begin
                    errors++;
                    $display("FAIL tile6_rgb got %h want ff0", s_rgb);
                end
            end
        end
    endtask

    task automatic test_frame();
        int unsigned vs_cnt, fs_cnt, fs_first, fs_second, fs_wide;
        logic prev_fs;
        vs_cnt = 0; fs_cnt = 0; fs_first = 0; fs_second = 0; fs_wide = 0;
        prev_fs = 1'b0;
        cursor = 4'($urandom_range(15));
        do_reset();
        while (n < 9000) begin
            cyc(1'b1);
            exp_b = model(cfg_big, n, cur_e2, last_en);
            exp_s = model(cfg_small, n, cur_e2, last_en);
            checks += 2;
            if (b_obs !== exp_b) begin
                errors++;
                $display("FAIL frame_big n=%0d got %h want %h", n, b_obs, exp_b);
            end
            if (s_obs !== exp_s) begin
                errors++;
                $display("FAIL frame_small n=%0d got %h want %h", n, s_obs, exp_s);
            end
            if (n >= 2 && n <= 4481 && !s_vs) vs_cnt++;
            if (s_fs) begin
                fs_cnt++;
                if (fs_first == 0) fs_first = n;
                else if (fs_second == 0) fs_second = n;
                if (prev_fs) fs_wide++;
            end
            prev_fs = s_fs;
            if (n == 8012) begin
                checks++;
                if ({b_de, b_rgb} !== {1'b1, 12'h444}) begin
                    errors++;
                    $display("FAIL background_pixel got de=%b rgb=%h want de=1 rgb=444", b_de, b_rgb);
                end
            end
            if (n == 8702) begin
                checks++;
                if ({b_de, b_rgb} !== {1'b0, 12'h000}) begin
                    errors++;
                    $display("FAIL blank_pixel got de=%b rgb=%h want de=0 rgb=000", b_de, b_rgb);
                end
            end
        end
        checks += 4;
        if (vs_cnt != 160) begin
            errors++;
            $display("FAIL vsync_low_ticks got %0d want 160", vs_cnt);
        end
        if (fs_cnt != 2 || fs_wide != 0) begin
            errors++;
            $display("FAIL frame_start_pulses got %0d (wide %0d) want 2 (wide 0)", fs_cnt, fs_wide);
        end
        if (fs_first != 4480) begin
            errors++;
            $display("FAIL frame_start_first got %0d want 4480", fs_first);
        end
        if (fs_second - fs_first != 4480) begin
            errors++;
            $display("FAIL frame_start_period got %0d want 4480", fs_second - fs_first);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) mem[i] = 3'($urandom_range(7));
        cursor = 4'($urandom_range(15));
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(31) == 0) cursor = 4'($urandom_range(15));
            cyc($urandom_range(3) != 0);
            exp_b = model(cfg_big, n, cur_e2, last_en);
            exp_s = model(cfg_small, n, cur_e2, last_en);
            checks += 2;
            if (b_obs !== exp_b) begin
                errors++;
                $display("FAIL random_big n=%0d got %h want %h", n, b_obs, exp_b);
            end
            if (s_obs !== exp_s) begin
                errors++;
                $display("FAIL random_small n=%0d got %h want %h", n, s_obs, exp_s);
            end
        end
    endtask

    task automatic test_half_rate();
        cursor = 4'($urandom_range(15));
        do_reset();
        for (int i = 0; i < 3400; i++) begin
            cyc(i % 2 == 1);
            exp_b = model(cfg_big, n, cur_e2, last_en);
            exp_s = model(cfg_small, n, cur_e2, last_en);
            checks += 2;
            if (b_obs !== exp_b) begin
                errors++;
                $display("FAIL half_big n=%0d got %h want %h", n, b_obs, exp_b);
            end
            if (s_obs !== exp_s) begin
                errors++;
                $display("FAIL half_small n=%0d got %h want %h", n, s_obs, exp_s);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [20:0] want;
        int unsigned fall1;
        logic prev_hs;
        want = {1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 4'h0};
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks += 2;
        if ({b_obs, b_addr} !== want) begin
            errors++;
            $display("FAIL midreset_big got %h want %h", {b_obs, b_addr}, want);
        end
        if ({s_obs, s_addr} !== want) begin
            errors++;
            $display("FAIL midreset_small got %h want %h", {s_obs, s_addr}, want);
        end
        n = 0;
        last_en = 1'b0;
        cur_e1 = cursor;
        cur_e2 = cursor;
        cyc(1'b0);
        cyc(1'b0);
        @(negedge clk);
        rst = 1'b1;
        fall1 = 0;
        prev_hs = 1'b1;
        for (int i = 0; i < 1800; i++) begin
            cyc(i % 2 == 0);
            exp_b = model(cfg_big, n, cur_e2, last_en);
            checks++;
            if (b_obs !== exp_b) begin
                errors++;
                $display("FAIL restart_big n=%0d got %h want %h", n, b_obs, exp_b);
            end
            if (prev_hs && !b_hs && fall1 == 0) fall1 = n;
            prev_hs = b_hs;
        end
        checks++;
        if (fall1 != 658) begin
            errors++;
            $display("FAIL restart_hsync_fall got %0d want 658", fall1);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        pix_en    = 1'b0;
        cursor    = 4'd0;
        n         = 0;
        last_en   = 1'b0;
        cur_e1    = 4'd0;
        cur_e2    = 4'd0;
        cfg_big   = '{640, 16, 96, 48, 480, 10, 2, 33, 192, 112, 6};
        cfg_small = '{64, 4, 8, 4, 48, 2, 2, 4, 16, 8, 3};
        test_reset();
        test_line_timing();
        test_tile_map();
        test_frame();
        test_random();
        test_half_rate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
